// File: rtl/fwrisc_regfile_dump.sv
// fwrisc_regfile_dump
//   Debug read-out engine for the 64-entry register file. On dump_req it
//   walks registers START_IDX..START_IDX+N_REGS-1 through the regfile's
//   synchronous read port. It streams a frame of HDR_BYTE followed by each
//   register, least significant byte first, over a valid/ready byte link.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   dump_req          start request (sampled only while idle)
//   dump_busy         high whenever the engine is not idle
//   dump_done         one-cycle pulse after the last byte is accepted
//   rf_raddr/rf_rdata regfile read port (data returns one cycle after address)
//   tx_data/tx_valid/tx_ready  byte stream towards the UART transmitter
module fwrisc_regfile_dump #(
  parameter int          N_REGS    = 32,
  parameter int          START_IDX = 0,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dump_req,
  output logic        dump_busy,
  output logic        dump_done,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [5:0] FIRST_IDX = 6'(START_IDX);
  localparam logic [5:0] LAST_IDX  = 6'(START_IDX + N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_CAP, S_SEND, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_idx;
  logic [5:0]  r_raddr;   // last address, held outside LOAD/CAP
  logic [1:0]  r_bcnt;
  logic [31:0] r_shift;
  logic        w_xfer;
  logic        w_last_byte;

  assign w_xfer      = tx_valid & tx_ready;
  assign w_last_byte = (r_bcnt == 2'd3);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    dump_busy = 1'b1;
    dump_done = 1'b0;
    rf_raddr  = r_raddr;
    case (r_state)
      S_IDLE: begin
        dump_busy = 1'b0;
        if (dump_req) w_next = S_HDR;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (w_xfer) w_next = S_LOAD;
      end
      S_LOAD: begin
        rf_raddr = r_idx;
        w_next   = S_CAP;
      end
      S_CAP: begin
        rf_raddr = r_idx;
        w_next   = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[7:0];
        if (w_xfer && w_last_byte) w_next = (r_idx == LAST_IDX) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        dump_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx   <= 6'd0;
      r_raddr <= 6'd0;
      r_bcnt  <= 2'd0;
      r_shift <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (dump_req) r_idx <= FIRST_IDX;
        S_CAP: begin
          // regfile registered the address in LOAD, so data is valid now
          r_shift <= rf_rdata;
          r_bcnt  <= 2'd0;
          r_raddr <= r_idx;
        end
        S_SEND: if (w_xfer) begin
          r_shift <= r_shift >> 8;
          r_bcnt  <= r_bcnt + 2'd1;
          if (w_last_byte && r_idx != LAST_IDX) r_idx <= r_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fwrisc_regfile_dump.md
Name: fwrisc_regfile_dump

Overview:
- Debug read-out engine for the 64-entry register file. It acts as the reader on the register file's synchronous read port.
- On request, it walks register indices START_IDX..START_IDX+N_REGS-1 and captures each 32-bit value. It streams the values as a framed byte sequence over a valid/ready byte interface into the UART transmitter.
- The integration layer muxes rf_raddr onto a register-file read port while dump_busy=1; the core is stalled during that time.

Parameters:
- N_REGS, 32, number of registers dumped; legal range 1..64.
- START_IDX, 0, first register index; START_IDX+N_REGS must be ≤ 64.
- HDR_BYTE, 8'hA5, frame header byte emitted before register data.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- dump_req  in  1  start request, sampled in IDLE only.
- dump_busy  out  1  high from the first non-IDLE state until return to IDLE.
- dump_done  out  1  one-cycle pulse when the last byte has been accepted.
- rf_raddr  out  6  register-file read address.
- rf_rdata  in  32  register-file read data; valid the cycle after rf_raddr is presented (address registered inside the regfile).
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts byte; transfer occurs when tx_valid&tx_ready at a rising edge.

Behaviour:
- Reset values: dump_busy=0, dump_done=0, tx_valid=0, tx_data=0, rf_raddr=0. State=IDLE, idx=0, byte counter=0, shift register=0. Reset acts immediately (asynchronously); tx_valid drops without waiting for a handshake.
- State machine:
  - IDLE: wait for dump_req.
  - HDR: output header byte.
  - LOAD: present read address.
  - CAP: capture read data.
  - SEND: output the four data bytes.
  - DONE: pulse completion.
- IDLE: if dump_req=1 at an edge → HDR; idx←START_IDX.
- HDR: tx_valid=1, tx_data=HDR_BYTE. On transfer → LOAD.
- LOAD: rf_raddr=idx; tx_valid=0. Always → CAP after 1 cycle.
- CAP: rf_raddr held at idx; shift←rf_rdata; bcnt←0. Always → SEND.
- SEND: tx_valid=1, tx_data=shift[7:0] (little-endian, LSB first).
  - On each transfer: shift←shift>>8, bcnt←bcnt+1.
  - On the transfer with bcnt=3: if idx==START_IDX+N_REGS-1 → DONE; else idx←idx+1 → LOAD.
- DONE: dump_done=1 for exactly one cycle; → IDLE. dump_busy=0 in IDLE only.
- rf_raddr holds its last value outside LOAD/CAP.
- Handshake rules:
  - tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0.
  - The block never retracts tx_valid before a transfer, except on reset.
  - tx_ready while tx_valid=0 is ignored.
- dump_req while busy is ignored; no queuing. dump_req held high across DONE starts a new dump on the IDLE cycle after DONE.
- Timing with tx_ready constantly 1: HDR occupies 1 cycle and each register occupies 6 cycles (LOAD, CAP, 4×SEND). dump_done is high exactly 1+6·N_REGS+1 cycles after the edge that sampled dump_req.
- Index arithmetic: idx is 6 bits and never wraps, because the parameter constraint guarantees the last index is ≤ 63.
- Data coherency: the value dumped is whatever the regfile returns in CAP. Register 0 reads as 0 by regfile construction. No snapshot semantics are provided; the core must be stalled.
- Frame length: 1+4·N_REGS bytes.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0, dump_busy=0. Release reset, idle 10 cycles with dump_req=0 → tx_valid stays 0.
- Basic dump: N_REGS=4, START_IDX=0; regfile model holds x1=32'h11223344, x2=32'hDEADBEEF, x3=32'h00000001; tx_ready=1; pulse dump_req.
  - Required bytes: A5, 00,00,00,00, 44,33,22,11, EF,BE,AD,DE, 01,00,00,00.
  - dump_done pulses 26 cycles after the request edge.
  - rf_raddr sequence during LOAD: 0,1,2,3.
- Backpressure: same setup with tx_ready toggling randomly, including 20-cycle low stretches → identical 17-byte sequence. tx_data/tx_valid stable whenever tx_ready=0. No bytes lost or duplicated.
- Busy and back-to-back requests: assert dump_req again mid-dump → ignored; exactly one frame. Hold dump_req high continuously → two consecutive frames, the second HDR starting 2 cycles after dump_done.
- Reset mid-dump: assert reset during SEND of register 2 byte 1 → tx_valid=0 and dump_busy=0 immediately, no dump_done. A later dump_req produces a full, correct frame.
- Offset range: START_IDX=60, N_REGS=4 → rf_raddr 60,61,62,63. 17 bytes; dump_done after the last byte of x63.
